// File: rtl/local_ni_pkg.sv
// local_ni_pkg: shared NoC constants and state encodings for the local
// network interface.
//   DEF_TAM_FLIT  default flit width in bits
//   METADEFLIT    bits per address coordinate (X or Y)
//   LOCAL_PORT    router port index of the local port
//   inj_state_e   injector FSM states
//   rx_state_e    receiver FSM states
package local_ni_pkg;

    localparam int DEF_TAM_FLIT = 16;
    localparam int METADEFLIT   = DEF_TAM_FLIT / 2;
    localparam int LOCAL_PORT   = 4;

    typedef enum logic [1:0] {
        I_IDLE    = 2'd0,
        I_SIZE    = 2'd1,
        I_PAYLOAD = 2'd2
    } inj_state_e;

    typedef enum logic [1:0] {
        R_HDR     = 2'd0,
        R_SIZE    = 2'd1,
        R_PAYLOAD = 2'd2
    } rx_state_e;

endpackage

// File: rtl/ni_rx_fifo.sv
// ni_rx_fifo: first-word-fall-through receive buffer.
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push/i_wdata write one entry (ignored when full unless popping too)
//   i_pop          remove the head entry (ignored when empty)
//   o_rdata        head entry, valid whenever !o_empty
//   o_full/o_empty occupancy flags
module ni_rx_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok, pop_ok;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop_ok  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok = i_push && (!o_full || pop_ok);

    assign o_rdata = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (pop_ok)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/local_ni.sv
// local_ni: network interface for one router's local port.
// Injector: host descriptor + payload words -> target, size, payload flits
// on the router local input, credit-controlled.
// Receiver: router local output -> strips target/size, flags misroutes,
// buffers payload words with last marking for the host.
//   i_clk, i_rst                       clock, async active-high reset
//   i_pkt_valid/o_pkt_ready,
//   i_pkt_target, i_pkt_len            descriptor handshake
//   i_pl_valid/o_pl_ready, i_pl_data   payload handshake
//   o_rx, o_data, i_credit             flits toward the router
//   i_tx, i_data, o_credit             flits from the router
//   o_rcv_valid/i_rcv_ready,
//   o_rcv_data, o_rcv_last             received payload to the host
//   o_misroute                         sticky wrong-destination flag
module local_ni
    import local_ni_pkg::*;
#(
    parameter int                 TAM_FLIT = DEF_TAM_FLIT,
    parameter logic [TAM_FLIT-1:0] ADDRESS = '0,
    parameter int                 RX_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pkt_valid,
    output logic                o_pkt_ready,
    input  logic [TAM_FLIT-1:0] i_pkt_target,
    input  logic [TAM_FLIT-1:0] i_pkt_len,
    input  logic                i_pl_valid,
    output logic                o_pl_ready,
    input  logic [TAM_FLIT-1:0] i_pl_data,
    output logic                o_rx,
    output logic [TAM_FLIT-1:0] o_data,
    input  logic                i_credit,
    input  logic                i_tx,
    input  logic [TAM_FLIT-1:0] i_data,
    output logic                o_credit,
    output logic                o_rcv_valid,
    input  logic                i_rcv_ready,
    output logic [TAM_FLIT-1:0] o_rcv_data,
    output logic                o_rcv_last,
    output logic                o_misroute
);

    localparam logic [TAM_FLIT-1:0] ONE = {{(TAM_FLIT-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Injector
    // ------------------------------------------------------------------
    inj_state_e          inj_state_q, inj_state_d;
    logic                rx_q, rx_d;
    logic [TAM_FLIT-1:0] data_q, data_d;
    logic [TAM_FLIT-1:0] len_q, len_d;
    logic [TAM_FLIT-1:0] cnt_q, cnt_d;
    logic                adv;

    // The output register may be reloaded when empty or being consumed.
    assign adv = !rx_q || i_credit;

    always_comb begin
        inj_state_d = inj_state_q;
        rx_d        = rx_q;
        data_d      = data_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        o_pkt_ready = 1'b0;
        o_pl_ready  = 1'b0;

        unique case (inj_state_q)
            I_IDLE: begin
                o_pkt_ready = adv && !i_rst;
                if (adv) begin
                    if (i_pkt_valid) begin
                        data_d      = i_pkt_target;
                        rx_d        = 1'b1;
                        len_d       = i_pkt_len;
                        inj_state_d = I_SIZE;
                    end else begin
                        rx_d = 1'b0;
                    end
                end
            end
            I_SIZE: begin
                if (adv) begin
                    data_d = len_q;
                    rx_d   = 1'b1;
                    cnt_d  = '0;
                    inj_state_d = (len_q == '0) ? I_IDLE : I_PAYLOAD;
                end
            end
            I_PAYLOAD: begin
                o_pl_ready = adv && !i_rst;
                if (adv) begin
                    if (i_pl_valid) begin
                        data_d = i_pl_data;
                        rx_d   = 1'b1;
                        cnt_d  = cnt_q + ONE;
                        // len_q is nonzero in this state, so len_q-1 is safe.
                        if (cnt_q == len_q - ONE) inj_state_d = I_IDLE;
                    end else begin
                        rx_d = 1'b0;
                    end
                end
            end
            default: begin
                inj_state_d = I_IDLE;
                rx_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inj_state_q <= I_IDLE;
            rx_q        <= 1'b0;
            data_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
        end else begin
            inj_state_q <= inj_state_d;
            rx_q        <= rx_d;
            data_q      <= data_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_rx   = rx_q;
    assign o_data = data_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_e           rx_state_q, rx_state_d;
    logic [TAM_FLIT-1:0] size_q, size_d;
    logic [TAM_FLIT-1:0] rcnt_q, rcnt_d;
    logic                misroute_q, misroute_d;
    logic                flit_in;
    logic                rx_last;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [TAM_FLIT:0]   fifo_rdata;

    // Credit is withheld on a full FIFO even when the host pops in the
    // same cycle; this keeps credit a pure function of registered state.
    assign o_credit = !fifo_full && !i_rst;
    assign flit_in  = i_tx && o_credit;
    assign rx_last  = (size_q != '0) && (rcnt_q == size_q - ONE);

    always_comb begin
        rx_state_d = rx_state_q;
        size_d     = size_q;
        rcnt_d     = rcnt_q;
        misroute_d = misroute_q;
        fifo_push  = 1'b0;

        if (flit_in) begin
            unique case (rx_state_q)
                R_HDR: begin
                    if (i_data != ADDRESS) misroute_d = 1'b1;
                    rx_state_d = R_SIZE;
                end
                R_SIZE: begin
                    size_d     = i_data;
                    rcnt_d     = '0;
                    rx_state_d = (i_data == '0) ? R_HDR : R_PAYLOAD;
                end
                R_PAYLOAD: begin
                    fifo_push = 1'b1;
                    rcnt_d    = rcnt_q + ONE;
                    if (rx_last) rx_state_d = R_HDR;
                end
                default: rx_state_d = R_HDR;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_state_q <= R_HDR;
            size_q     <= '0;
            rcnt_q     <= '0;
            misroute_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            size_q     <= size_d;
            rcnt_q     <= rcnt_d;
            misroute_q <= misroute_d;
        end
    end

    assign o_misroute = misroute_q;

    assign o_rcv_valid = !fifo_empty && !i_rst;
    assign fifo_pop    = o_rcv_valid && i_rcv_ready;

    ni_rx_fifo #(
        .W     (TAM_FLIT + 1),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_wdata ({rx_last, i_data}),
        .i_pop   (fifo_pop),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_rcv_last = fifo_rdata[TAM_FLIT];
    assign o_rcv_data = fifo_rdata[TAM_FLIT-1:0];

endmodule

// File: tb/tb_local_ni.sv
module tb_local_ni;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_pkt_valid;
    logic        o_pkt_ready;
    logic [15:0] i_pkt_target;
    logic [15:0] i_pkt_len;
    logic        i_pl_valid;
    logic        o_pl_ready;
    logic [15:0] i_pl_data;
    logic        o_rx;
    logic [15:0] o_data;
    logic        i_credit;
    logic        i_tx;
    logic [15:0] i_data;
    logic        o_credit;
    logic        o_rcv_valid;
    logic        i_rcv_ready;
    logic [15:0] o_rcv_data;
    logic        o_rcv_last;
    logic        o_misroute;

    int checks   = 0;
    int failures = 0;

    logic [15:0] tx_log[$];
    logic [16:0] rx_log[$];
    logic [15:0] exp_tx[$];
    logic [16:0] exp_rx[$];

    local_ni #(
        .TAM_FLIT (16),
        .ADDRESS  (16'h0011),
        .RX_DEPTH (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pkt_valid  (i_pkt_valid),
        .o_pkt_ready  (o_pkt_ready),
        .i_pkt_target (i_pkt_target),
        .i_pkt_len    (i_pkt_len),
        .i_pl_valid   (i_pl_valid),
        .o_pl_ready   (o_pl_ready),
        .i_pl_data    (i_pl_data),
        .o_rx         (o_rx),
        .o_data       (o_data),
        .i_credit     (i_credit),
        .i_tx         (i_tx),
        .i_data       (i_data),
        .o_credit     (o_credit),
        .o_rcv_valid  (o_rcv_valid),
        .i_rcv_ready  (i_rcv_ready),
        .o_rcv_data   (o_rcv_data),
        .o_rcv_last   (o_rcv_last),
        .o_misroute   (o_misroute)
    );

    always #5 i_clk = ~i_clk;

    // Record every flit/word that actually changes hands.
    always @(posedge i_clk) begin
        if (o_rx && i_credit) tx_log.push_back(o_data);
        if (o_rcv_valid && i_rcv_ready) rx_log.push_back({o_rcv_last, o_rcv_data});
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_tx(input string tag);
        check({tag, "_count"}, tx_log.size(), exp_tx.size());
        for (int k = 0; k < exp_tx.size() && k < tx_log.size(); k++)
            check($sformatf("%s_flit%0d", tag, k), {16'h0, tx_log[k]}, {16'h0, exp_tx[k]});
        tx_log.delete();
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, rx_log.size(), exp_rx.size());
        for (int k = 0; k < exp_rx.size() && k < rx_log.size(); k++)
            check($sformatf("%s_word%0d", tag, k), {15'h0, rx_log[k]}, {15'h0, exp_rx[k]});
        rx_log.delete();
    endtask

    // Offer one flit from the router; waits (bounded) for credit.
    task automatic send_flit(input logic [15:0] d);
        i_tx   = 1'b1;
        i_data = d;
        for (int k = 0; k < 20 && !o_credit; k++) cyc();
        check("rx_credit_wait", {31'h0, o_credit}, 32'h1);
        cyc();
        i_tx = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_pkt_valid = 0; i_pkt_target = 0; i_pkt_len = 0;
        i_pl_valid = 0; i_pl_data = 0; i_credit = 1'b1;
        i_tx = 0; i_data = 0; i_rcv_ready = 0;

        // ---------------- reset state ----------------
        repeat (3) cyc();
        check("rst_o_rx", {31'h0, o_rx}, 32'h0);
        check("rst_o_data", {16'h0, o_data}, 32'h0);
        check("rst_misroute", {31'h0, o_misroute}, 32'h0);
        check("rst_pkt_ready", {31'h0, o_pkt_ready}, 32'h0);
        check("rst_pl_ready", {31'h0, o_pl_ready}, 32'h0);
        check("rst_credit", {31'h0, o_credit}, 32'h0);
        check("rst_rcv_valid", {31'h0, o_rcv_valid}, 32'h0);
        i_rst = 1'b0;
        #1;
        check("idle_pkt_ready", {31'h0, o_pkt_ready}, 32'h1);
        check("idle_credit", {31'h0, o_credit}, 32'h1);
        tx_log.delete();

        // ---------------- test 1: len 3 packet ----------------
        i_pkt_valid = 1; i_pkt_target = 16'h0022; i_pkt_len = 16'd3;
        #1 check("t1_pkt_ready", {31'h0, o_pkt_ready}, 32'h1);
        cyc();
        i_pkt_valid = 0; i_pl_valid = 1; i_pl_data = 16'h00A1;
        #1 check("t1_target", {16'h0, o_data}, 32'h0022);
        check("t1_target_rx", {31'h0, o_rx}, 32'h1);
        check("t1_pl_ready_size", {31'h0, o_pl_ready}, 32'h0);
        cyc();
        check("t1_size", {16'h0, o_data}, 32'h0003);
        check("t1_pl_ready", {31'h0, o_pl_ready}, 32'h1);
        cyc();
        check("t1_a1", {16'h0, o_data}, 32'h00A1);
        i_pl_data = 16'h00A2;
        cyc();
        check("t1_a2", {16'h0, o_data}, 32'h00A2);
        i_pl_data = 16'h00A3;
        cyc();
        check("t1_a3", {16'h0, o_data}, 32'h00A3);
        i_pl_valid = 0;
        cyc();
        check("t1_rx_idle", {31'h0, o_rx}, 32'h0);
        exp_tx = '{16'h0022, 16'h0003, 16'h00A1, 16'h00A2, 16'h00A3};
        check_tx("t1_log");

        // ---------------- test 2: len 0 then back-to-back ----------------
        i_pkt_valid = 1; i_pkt_target = 16'h0044; i_pkt_len = 16'd0;
        cyc();
        i_pkt_target = 16'h0055; i_pkt_len = 16'd1;
        #1 check("t2_target", {16'h0, o_data}, 32'h0044);
        check("t2_busy_ready", {31'h0, o_pkt_ready}, 32'h0);
        cyc();
        check("t2_size0", {16'h0, o_data}, 32'h0000);
        check("t2_size0_rx", {31'h0, o_rx}, 32'h1);
        check("t2_next_ready", {31'h0, o_pkt_ready}, 32'h1);
        cyc();
        i_pkt_valid = 0;
        check("t2_next_target", {16'h0, o_data}, 32'h0055);
        cyc();
        i_pl_valid = 1; i_pl_data = 16'h00C1;
        check("t2_next_size", {16'h0, o_data}, 32'h0001);
        cyc();
        i_pl_valid = 0;
        check("t2_c1", {16'h0, o_data}, 32'h00C1);
        cyc();
        check("t2_rx_idle", {31'h0, o_rx}, 32'h0);
        exp_tx = '{16'h0044, 16'h0000, 16'h0055, 16'h0001, 16'h00C1};
        check_tx("t2_log");

        // ---------------- test 3: credit stall mid-payload ----------------
        i_pkt_valid = 1; i_pkt_target = 16'h0066; i_pkt_len = 16'd4;
        cyc();
        i_pkt_valid = 0; i_pl_valid = 1; i_pl_data = 16'h00D1;
        check("t3_target", {16'h0, o_data}, 32'h0066);
        cyc();
        check("t3_size", {16'h0, o_data}, 32'h0004);
        cyc();
        i_credit = 0; i_pl_data = 16'h00D2;
        #1 check("t3_stall_pl_ready", {31'h0, o_pl_ready}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t3_stall%0d_data", k), {16'h0, o_data}, 32'h00D1);
            check($sformatf("t3_stall%0d_rx", k), {31'h0, o_rx}, 32'h1);
            cyc();
        end
        i_credit = 1;
        check("t3_resume_data", {16'h0, o_data}, 32'h00D1);
        cyc();
        check("t3_d2", {16'h0, o_data}, 32'h00D2);
        i_pl_data = 16'h00D3;
        cyc();
        check("t3_d3", {16'h0, o_data}, 32'h00D3);
        i_pl_data = 16'h00D4;
        cyc();
        check("t3_d4", {16'h0, o_data}, 32'h00D4);
        i_pl_valid = 0;
        cyc();
        check("t3_rx_idle", {31'h0, o_rx}, 32'h0);
        exp_tx = '{16'h0066, 16'h0004, 16'h00D1, 16'h00D2, 16'h00D3, 16'h00D4};
        check_tx("t3_log");

        // ---------------- test 4: receive, host not ready ----------------
        rx_log.delete();
        i_rcv_ready = 0;
        send_flit(16'h0011);
        send_flit(16'h0002);
        send_flit(16'h00B1);
        send_flit(16'h00B2);
        check("t4_valid", {31'h0, o_rcv_valid}, 32'h1);
        check("t4_head", {16'h0, o_rcv_data}, 32'h00B1);
        check("t4_head_last", {31'h0, o_rcv_last}, 32'h0);
        check("t4_misroute", {31'h0, o_misroute}, 32'h0);
        i_rcv_ready = 1;
        cyc();
        check("t4_second", {16'h0, o_rcv_data}, 32'h00B2);
        check("t4_second_last", {31'h0, o_rcv_last}, 32'h1);
        cyc();
        check("t4_empty", {31'h0, o_rcv_valid}, 32'h0);
        i_rcv_ready = 0;
        exp_rx = '{17'h000B1, 17'h100B2};
        check_rx("t4_log");

        // ---------------- test 5: FIFO fill and backpressure ----------------
        send_flit(16'h0011);
        send_flit(16'h0006);
        send_flit(16'h00E1);
        send_flit(16'h00E2);
        send_flit(16'h00E3);
        check("t5_credit_before_full", {31'h0, o_credit}, 32'h1);
        send_flit(16'h00E4);
        check("t5_credit_full", {31'h0, o_credit}, 32'h0);
        check("t5_head", {16'h0, o_rcv_data}, 32'h00E1);
        i_rcv_ready = 1;
        send_flit(16'h00E5);
        send_flit(16'h00E6);
        repeat (8) cyc();
        check("t5_drained", {31'h0, o_rcv_valid}, 32'h0);
        i_rcv_ready = 0;
        exp_rx = '{17'h000E1, 17'h000E2, 17'h000E3, 17'h000E4, 17'h000E5, 17'h100E6};
        check_rx("t5_log");

        // ---------------- test 6: misroute and async reset ----------------
        send_flit(16'h0033);
        send_flit(16'h0000);
        check("t6_misroute_set", {31'h0, o_misroute}, 32'h1);
        send_flit(16'h0011);
        send_flit(16'h0001);
        send_flit(16'h00F1);
        check("t6_misroute_sticky", {31'h0, o_misroute}, 32'h1);
        check("t6_fifo_valid", {31'h0, o_rcv_valid}, 32'h1);
        i_pkt_valid = 1; i_pkt_target = 16'h0077; i_pkt_len = 16'd2;
        cyc();
        i_pkt_valid = 0;
        check("t6_pre_rst_rx", {31'h0, o_rx}, 32'h1);
        #3 i_rst = 1'b1;
        #1;
        check("t6_rst_o_rx", {31'h0, o_rx}, 32'h0);
        check("t6_rst_o_data", {16'h0, o_data}, 32'h0);
        check("t6_rst_misroute", {31'h0, o_misroute}, 32'h0);
        check("t6_rst_pkt_ready", {31'h0, o_pkt_ready}, 32'h0);
        check("t6_rst_pl_ready", {31'h0, o_pl_ready}, 32'h0);
        check("t6_rst_credit", {31'h0, o_credit}, 32'h0);
        check("t6_rst_rcv_valid", {31'h0, o_rcv_valid}, 32'h0);
        cyc();
        i_rst = 1'b0;
        #1;
        check("t6_post_pkt_ready", {31'h0, o_pkt_ready}, 32'h1);
        check("t6_post_rcv_valid", {31'h0, o_rcv_valid}, 32'h0);
        check("t6_post_credit", {31'h0, o_credit}, 32'h1);
        check("t6_post_misroute", {31'h0, o_misroute}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
